drc_burst_packer: RTL and testbench

Per-path upstream stage of the DMA read controller: accepts a transfer command (start address, beat count) and a 128-bit beat stream, splits the transfer into AXI-legal bursts, and buffers them for the AXI write pusher. Data beats go into a show-ahead data FIFO. A 40-bit burst descriptor is queued only after the last beat of that burst is in the data FIFO, so the pusher never underruns mid-burst. One instance per path; the read-side ports connect to one lane of the pusher's path buses.

---
 rtl/drc_burst_packer.sv | 167 ++++++++++++++++
 tb/tb_drc_burst_packer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/drc_burst_packer.sv
// Burst packer for one DMA read-controller path.
// Splits a (start address, beat count) transfer into bursts that respect the
// beat limit and never cross a 4 KB page, buffers the 128-bit beats in a
// show-ahead data FIFO, and queues each burst descriptor only once the
// burst's last beat is already stored, so the pusher never runs dry mid-burst.
module drc_burst_packer #(
    parameter int p_max_beats   = 16,
    parameter int p_data_depth  = 64,
    parameter int p_burst_depth = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [31:0]  i_cmd_addr,
    input  logic [15:0]  i_cmd_beats,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [127:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic         o_busy,
    input  logic         burst_rd,
    output logic [39:0]  burst_out,
    output logic         burst_empty,
    input  logic         data_rd,
    output logic [127:0] data_out,
    output logic         data_empty
);
    localparam int DAW = $clog2(p_data_depth);
    localparam int BAW = $clog2(p_burst_depth);
    localparam logic [6:0]   MAX_BEATS  = 7'(p_max_beats);
    localparam logic [DAW:0] DATA_FULL  = (DAW + 1)'(p_data_depth);
    localparam logic [BAW:0] BURST_FULL = (BAW + 1)'(p_burst_depth);
    localparam logic [0:0]   IDLE = 1'b0;
    localparam logic [0:0]   FILL = 1'b1;

    logic [0:0]  state;
    logic [31:0] addr;
    logic [15:0] remaining;
    logic [6:0]  beat_cnt;
    logic [6:0]  len_q;
    logic [8:0]  to_4k;
    logic [6:0]  len_cap;
    logic [6:0]  len_new;
    logic [6:0]  cur_len;
    logic [31:0] cmd_addr_al;
    logic        beat_ok;
    logic        burst_last;

    logic [127:0]   data_mem [p_data_depth];
    logic [DAW-1:0] data_wp;
    logic [DAW-1:0] data_rp;
    logic [DAW:0]   data_cnt;
    logic           data_full;
    logic           data_pop;

    logic [39:0]    burst_mem [p_burst_depth];
    logic [BAW-1:0] burst_wp;
    logic [BAW-1:0] burst_rp;
    logic [BAW:0]   burst_cnt;
    logic           burst_full;
    logic           burst_pop;

    // The low four address bits are dropped: every beat is 16-byte aligned.
    assign cmd_addr_al = i_cmd_addr & 32'hFFFF_FFF0;

    // Length of a burst starting now: min(remaining, beat limit, beats left in the 4 KB page).
    always_comb begin
        to_4k   = 9'd256 - {1'b0, addr[11:4]};
        len_cap = MAX_BEATS;
        if (to_4k < {2'b0, MAX_BEATS}) len_cap = to_4k[6:0];
        len_new = len_cap;
        if (remaining < {9'b0, len_cap}) len_new = remaining[6:0];
    end

    // The length is frozen at the first beat; later beats use the latched copy.
    assign cur_len     = (beat_cnt == 7'd0) ? len_new : len_q;
    assign o_ready     = (state == FILL) && !data_full && !burst_full;
    assign o_cmd_ready = (state == IDLE);
    assign o_busy      = (state == FILL);
    assign beat_ok     = i_valid && o_ready;
    assign burst_last  = beat_ok && ((beat_cnt + 7'd1) == cur_len);

    // Command latch and burst slicing state machine.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            len_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        addr      <= cmd_addr_al;
                        remaining <= i_cmd_beats;
                        beat_cnt  <= '0;
                        if (i_cmd_beats != 16'd0) state <= FILL;
                    end
                end
                FILL: begin
                    if (beat_ok) begin
                        remaining <= remaining - 16'd1;
                        if (beat_cnt == 7'd0) len_q <= len_new;
                        if (burst_last) begin
                            beat_cnt <= '0;
                            addr     <= addr + {21'b0, cur_len, 4'b0};
                            if (remaining == 16'd1) state <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 7'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data FIFO storage; contents need no reset because the count gates the head.
    always_ff @(posedge i_clk) begin
        if (beat_ok) data_mem[data_wp] <= i_data;
    end

    assign data_pop   = data_rd && !data_empty;
    assign data_empty = (data_cnt == '0);
    assign data_full  = (data_cnt == DATA_FULL);
    assign data_out   = data_empty ? '0 : data_mem[data_rp];

    // Data FIFO pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_wp  <= '0;
            data_rp  <= '0;
            data_cnt <= '0;
        end else begin
            if (beat_ok)  data_wp <= data_wp + 1'b1;
            if (data_pop) data_rp <= data_rp + 1'b1;
            if (beat_ok && !data_pop)      data_cnt <= data_cnt + 1'b1;
            else if (!beat_ok && data_pop) data_cnt <= data_cnt - 1'b1;
        end
    end

    // Descriptor FIFO storage, written on the same edge as the burst's last beat.
    always_ff @(posedge i_clk) begin
        if (burst_last) burst_mem[burst_wp] <= {addr, 1'b0, cur_len};
    end

    assign burst_pop   = burst_rd && !burst_empty;
    assign burst_empty = (burst_cnt == '0);
    assign burst_full  = (burst_cnt == BURST_FULL);
    assign burst_out   = burst_empty ? '0 : burst_mem[burst_rp];

    // Descriptor FIFO pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            burst_wp  <= '0;
            burst_rp  <= '0;
            burst_cnt <= '0;
        end else begin
            if (burst_last) burst_wp <= burst_wp + 1'b1;
            if (burst_pop)  burst_rp <= burst_rp + 1'b1;
            if (burst_last && !burst_pop)      burst_cnt <= burst_cnt + 1'b1;
            else if (!burst_last && burst_pop) burst_cnt <= burst_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_drc_burst_packer.sv
// Bench for drc_burst_packer: random producer/consumer traffic against a
// queue-based reference model of the expected beats and descriptors.
module tb_drc_burst_packer;
    logic         clk;
    logic         rst_n;
    logic [31:0]  i_cmd_addr;
    logic [15:0]  i_cmd_beats;
    logic         i_cmd_valid;
    logic         o_cmd_ready;
    logic [127:0] i_data;
    logic         i_valid;
    logic         o_ready;
    logic         o_busy;
    logic         burst_rd;
    logic [39:0]  burst_out;
    logic         burst_empty;
    logic         data_rd;
    logic [127:0] data_out;
    logic         data_empty;

    drc_burst_packer #(
        .p_max_beats  (16),
        .p_data_depth (64),
        .p_burst_depth(8)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_cmd_addr (i_cmd_addr),
        .i_cmd_beats(i_cmd_beats),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_busy     (o_busy),
        .burst_rd   (burst_rd),
        .burst_out  (burst_out),
        .burst_empty(burst_empty),
        .data_rd    (data_rd),
        .data_out   (data_out),
        .data_empty (data_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [127:0] exp_data[$];
    logic [39:0]  exp_burst[$];
    logic [127:0] send_q[$];
    logic [31:0]  pb_addr[$];
    int           pb_len[$];
    bit           model_busy = 1'b0;
    bit           cmd_pend = 1'b0;
    logic [31:0]  cmd_a = '0;
    logic [15:0]  cmd_b = '0;
    int           beat_in_burst = 0;
    int           acc_total = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Slice a transfer into bursts straight from the rules: beat limit, 4 KB page, remaining.
    task automatic plan(input logic [31:0] a, input logic [15:0] b);
        logic [31:0] base;
        int rem;
        int room;
        int l;
        base = a & 32'hFFFF_FFF0;
        rem  = int'(b);
        while (rem > 0) begin
            room = 4096 - int'(base[11:0]);
            room = room / 16;
            l = rem;
            if (l > 16) l = 16;
            if (l > room) l = room;
            pb_addr.push_back(base);
            pb_len.push_back(l);
            base = base + 32'(l * 16);
            rem  = rem - l;
        end
        for (int i = 0; i < int'(b); i++) send_q.push_back(rnd128());
        model_busy    = (b != 16'd0);
        beat_in_burst = 0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [15:0] b);
        cmd_pend = 1'b1;
        cmd_a    = a;
        cmd_b    = b;
    endtask

    task automatic check_outputs();
        check("cmd_ready",   128'(o_cmd_ready), 128'(!model_busy));
        check("busy",        128'(o_busy),      128'(model_busy));
        check("ready",       128'(o_ready),
              128'(model_busy && exp_data.size() < 64 && exp_burst.size() < 8));
        check("data_empty",  128'(data_empty),  128'(exp_data.size() == 0));
        check("burst_empty", 128'(burst_empty), 128'(exp_burst.size() == 0));
        if (exp_data.size() > 0)  check("data_head",  data_out, exp_data[0]);
        if (exp_burst.size() > 0) check("burst_head", 128'(burst_out), 128'(exp_burst[0]));
    endtask

    // One clock: drive after the edge, check and commit handshakes at the negedge.
    task automatic step(input int vpct, input int dpct, input int bpct);
        bit dpop;
        bit bpop;
        bit acc_cmd;
        bit acc_beat;
        i_cmd_valid = cmd_pend;
        i_cmd_addr  = cmd_a;
        i_cmd_beats = cmd_b;
        if (send_q.size() > 0 && $urandom_range(0, 99) < vpct) begin
            i_valid = 1'b1;
            i_data  = send_q[0];
        end else begin
            i_valid = 1'b0;
            i_data  = rnd128();
        end
        data_rd  = ($urandom_range(0, 99) < dpct);
        burst_rd = ($urandom_range(0, 99) < bpct);
        @(negedge clk);
        check_outputs();
        dpop     = data_rd && exp_data.size() > 0;
        bpop     = burst_rd && exp_burst.size() > 0;
        acc_cmd  = i_cmd_valid && o_cmd_ready;
        acc_beat = i_valid && o_ready;
        if (dpop) void'(exp_data.pop_front());
        if (bpop) void'(exp_burst.pop_front());
        if (acc_beat && pb_len.size() > 0) begin
            exp_data.push_back(i_data);
            void'(send_q.pop_front());
            acc_total++;
            beat_in_burst++;
            if (beat_in_burst == pb_len[0]) begin
                exp_burst.push_back({pb_addr[0], 1'b0, 7'(pb_len[0])});
                void'(pb_addr.pop_front());
                void'(pb_len.pop_front());
                beat_in_burst = 0;
                if (pb_len.size() == 0) model_busy = 1'b0;
            end
        end
        if (acc_cmd) begin
            plan(cmd_a, cmd_b);
            cmd_pend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Run until the command is finished (and, if full, both FIFOs drained), bounded.
    task automatic drain(input int vpct, input int dpct, input int bpct, input int budget, input bit full);
        int n;
        n = 0;
        while ((cmd_pend || model_busy ||
                (full && (exp_data.size() > 0 || exp_burst.size() > 0))) && n < budget) begin
            step(vpct, dpct, bpct);
            n++;
        end
        check("drain_bound", 128'(n < budget), 128'(1));
    endtask

    task automatic clear_model();
        exp_data.delete();
        exp_burst.delete();
        send_q.delete();
        pb_addr.delete();
        pb_len.delete();
        model_busy    = 1'b0;
        cmd_pend      = 1'b0;
        beat_in_burst = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        int n;
        logic [31:0] ra;
        rst_n       = 1'b0;
        i_cmd_addr  = '0;
        i_cmd_beats = '0;
        i_cmd_valid = 1'b0;
        i_data      = '0;
        i_valid     = 1'b0;
        burst_rd    = 1'b0;
        data_rd     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready",   128'(o_cmd_ready), 128'(1));
        check("rst_ready",       128'(o_ready),     128'(0));
        check("rst_busy",        128'(o_busy),      128'(0));
        check("rst_burst_empty", 128'(burst_empty), 128'(1));
        check("rst_data_empty",  128'(data_empty),  128'(1));
        check("rst_burst_out",   128'(burst_out),   128'(0));
        check("rst_data_out",    data_out,          128'(0));
        rst_n = 1'b1;

        // Aligned 40-beat transfer, consumer always ready
        issue(32'h0000_1000, 16'd40);
        drain(100, 100, 100, 400, 1'b1);

        // 4 KB page split
        issue(32'h0000_0F80, 16'd20);
        drain(100, 100, 100, 400, 1'b1);

        // Zero-length command emits nothing
        issue(32'h0000_5000, 16'd0);
        drain(100, 100, 100, 50, 1'b1);
        repeat (4) step(100, 100, 100);

        // Address wrap at 2^32 with ignored low bits
        issue(32'hFFFF_FFC5, 16'd10);
        drain(100, 60, 60, 400, 1'b1);

        // Idle consumer: data FIFO fills at 64, one pop lets exactly one more in
        snap = acc_total;
        issue(32'h0000_3000, 16'd100);
        repeat (80) step(100, 0, 0);
        check("bp_stall_count", 128'(acc_total - snap), 128'(64));
        step(100, 100, 0);
        step(100, 0, 0);
        check("bp_refill_count", 128'(acc_total - snap), 128'(65));
        drain(100, 70, 70, 2000, 1'b1);

        // Asynchronous reset after 7 of 16 beats
        snap = acc_total;
        issue(32'h0000_2000, 16'd16);
        n = 0;
        while (acc_total - snap < 7 && n < 50) begin
            step(100, 0, 0);
            n++;
        end
        check("mid_beats", 128'(acc_total - snap), 128'(7));
        i_valid     = 1'b0;
        i_cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_burst_empty", 128'(burst_empty), 128'(1));
        check("mid_data_empty",  128'(data_empty),  128'(1));
        check("mid_ready",       128'(o_ready),     128'(0));
        check("mid_cmd_ready",   128'(o_cmd_ready), 128'(1));
        clear_model();
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(32'h0000_2040, 16'd30);
        drain(80, 60, 60, 1000, 1'b1);

        // Random traffic, back-to-back commands, random ready/valid
        for (int k = 0; k < 16; k++) begin
            ra = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 4095));
            issue(ra, 16'($urandom_range(0, 70)));
            drain(70, 55, 45, 3000, (k % 4) == 3);
        end
        drain(70, 60, 60, 3000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
